// File: rtl/sr_mem_arbiter_pkg.sv
// Shared types for the fetch/data memory arbiter: FSM state encodings,
// grant tags and the two-way round-robin pick.
package sr_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic {
        GNT_FETCH = 1'b0,
        GNT_DATA  = 1'b1
    } grant_e;

    localparam logic [3:0] FETCH_BE = 4'hF;

    // On a tie the port that did not win last time goes first.
    function automatic grant_e rr_pick(input logic req_fetch, input logic req_data,
                                       input grant_e last);
        grant_e win;
        if (req_fetch && req_data) begin
            win = (last == GNT_FETCH) ? GNT_DATA : GNT_FETCH;
        end else if (req_data) begin
            win = GNT_DATA;
        end else begin
            win = GNT_FETCH;
        end
        return win;
    endfunction

endpackage

// File: rtl/sr_mem_arbiter_if.sv
// Bundle of the fetch port, data port and shared memory port signals.
// Handshake: a requester holds x_req and its fields until it sees the one-cycle
// x_ack; the arbiter holds mem_req and mem_* stable until the one-cycle mem_ack.
interface sr_mem_arbiter_if;

    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic        i_err;
    logic [31:0] i_rdata;

    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic        d_err;
    logic [31:0] d_rdata;

    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    // Arbiter side.
    modport slave (
        input  i_req, i_addr,
        input  d_req, d_we, d_be, d_addr, d_wdata,
        input  mem_rdata, mem_ack,
        output i_ack, i_err, i_rdata,
        output d_ack, d_err, d_rdata,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );

    // Requesters and memory model side.
    modport master (
        output i_req, i_addr,
        output d_req, d_we, d_be, d_addr, d_wdata,
        output mem_rdata, mem_ack,
        input  i_ack, i_err, i_rdata,
        input  d_ack, d_err, d_rdata,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );

endinterface

// File: rtl/sr_mem_arbiter_rr_arb2.sv
// Combinational two-way round-robin arbiter between the fetch and data ports.
module sr_rr_arb2
    import sr_mem_arbiter_pkg::*;
(
    input  logic   req_fetch_i,
    input  logic   req_data_i,
    input  grant_e last_i,
    output logic   gnt_o,
    output grant_e win_o
);

    assign gnt_o = req_fetch_i | req_data_i;
    assign win_o = rr_pick(req_fetch_i, req_data_i, last_i);

endmodule

// File: rtl/sr_mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one memory port, one
// transaction at a time, with a BUSY-cycle timeout producing an error completion.
module sr_mem_arbiter
    import sr_mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 255
)
(
    input  logic              clk,
    input  logic              rst,
    sr_mem_arbiter_if.slave   bus,
    output state_e            state_o
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e           state_q;
    grant_e           last_q;
    grant_e           win_q;
    logic [CNT_W-1:0] cnt_q;

    logic        mem_req_q;
    logic        mem_we_q;
    logic [3:0]  mem_be_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;

    logic        i_ack_q;
    logic        i_err_q;
    logic [31:0] i_rdata_q;
    logic        d_ack_q;
    logic        d_err_q;
    logic [31:0] d_rdata_q;

    logic        gnt;
    grant_e      win_d;
    logic        finish;
    logic [31:0] done_rdata;

    sr_rr_arb2 u_rr_arb2 (
        .req_fetch_i (bus.i_req),
        .req_data_i  (bus.d_req),
        .last_i      (last_q),
        .gnt_o       (gnt),
        .win_o       (win_d)
    );

    // An ack landing on the final BUSY cycle beats the timeout.
    assign finish     = bus.mem_ack || (cnt_q == CNT_LAST);
    assign done_rdata = bus.mem_ack ? bus.mem_rdata : 32'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            last_q      <= GNT_FETCH;
            win_q       <= GNT_FETCH;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'h0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            i_ack_q     <= 1'b0;
            i_err_q     <= 1'b0;
            i_rdata_q   <= 32'd0;
            d_ack_q     <= 1'b0;
            d_err_q     <= 1'b0;
            d_rdata_q   <= 32'd0;
        end else begin
            i_ack_q <= 1'b0;
            i_err_q <= 1'b0;
            d_ack_q <= 1'b0;
            d_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (gnt) begin
                        win_q     <= win_d;
                        last_q    <= win_d;
                        cnt_q     <= '0;
                        mem_req_q <= 1'b1;
                        state_q   <= ST_BUSY;
                        if (win_d == GNT_DATA) begin
                            mem_we_q    <= bus.d_we;
                            mem_be_q    <= bus.d_be;
                            mem_addr_q  <= bus.d_addr;
                            mem_wdata_q <= bus.d_wdata;
                        end else begin
                            mem_we_q    <= 1'b0;
                            mem_be_q    <= FETCH_BE;
                            mem_addr_q  <= bus.i_addr;
                            mem_wdata_q <= 32'd0;
                        end
                    end
                end
                ST_BUSY: begin
                    if (finish) begin
                        mem_req_q <= 1'b0;
                        state_q   <= ST_DONE;
                        if (win_q == GNT_DATA) begin
                            d_ack_q   <= 1'b1;
                            d_err_q   <= ~bus.mem_ack;
                            d_rdata_q <= done_rdata;
                        end else begin
                            i_ack_q   <= 1'b1;
                            i_err_q   <= ~bus.mem_ack;
                            i_rdata_q <= done_rdata;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.i_ack     = i_ack_q;
    assign bus.i_err     = i_err_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.d_err     = d_err_q;
    assign bus.d_rdata   = d_rdata_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_sr_mem_arbiter.sv
// Directed bench for sr_mem_arbiter (TIMEOUT=4): lone fetch, tie after reset,
// sustained contention, timeout, ack/timeout collision and reset mid-BUSY.
module tb_sr_mem_arbiter;
    import sr_mem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    state_e      state;
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_tag;

    sr_mem_arbiter_if bus_if ();

    sr_mem_arbiter #(.TIMEOUT(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus_if),
        .state_o (state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%08h expected=%08h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) chk("ack_excl", 32'(bus_if.i_ack & bus_if.d_ack), 32'd0);
    end

    // ---------------- drivers ----------------
    task automatic drive_idle();
        bus_if.i_req     = 1'b0;
        bus_if.i_addr    = 32'd0;
        bus_if.d_req     = 1'b0;
        bus_if.d_we      = 1'b0;
        bus_if.d_be      = 4'h0;
        bus_if.d_addr    = 32'd0;
        bus_if.d_wdata   = 32'd0;
        bus_if.mem_ack   = 1'b0;
        bus_if.mem_rdata = 32'd0;
    endtask

    task automatic mem_respond(input logic [31:0] rdata);
        bus_if.mem_ack   = 1'b1;
        bus_if.mem_rdata = rdata;
    endtask

    task automatic mem_quiet();
        bus_if.mem_ack   = 1'b0;
        bus_if.mem_rdata = 32'd0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        drive_idle();
        rst = 1'b1;
        tick();
        tick();
        chk("rst_state",   32'(state),             32'(ST_IDLE));
        chk("rst_mem_req", 32'(bus_if.mem_req),    32'd0);
        chk("rst_mem_be",  32'(bus_if.mem_be),     32'd0);
        chk("rst_mem_adr", bus_if.mem_addr,        32'd0);
        chk("rst_acks",    32'({bus_if.i_ack, bus_if.i_err, bus_if.d_ack, bus_if.d_err}), 32'd0);
        chk("rst_rdata",   bus_if.i_rdata | bus_if.d_rdata, 32'd0);
        rst = 1'b0;

        // Lone fetch, minimum latency.
        bus_if.i_req  = 1'b1;
        bus_if.i_addr = 32'h40;
        tick();
        chk("f1_state", 32'(state),          32'(ST_BUSY));
        chk("f1_req",   32'(bus_if.mem_req), 32'd1);
        chk("f1_addr",  bus_if.mem_addr,     32'h40);
        chk("f1_be",    32'(bus_if.mem_be),  32'hF);
        chk("f1_we",    32'(bus_if.mem_we),  32'd0);
        chk("f1_wdata", bus_if.mem_wdata,    32'd0);
        mem_respond(32'h0050_0093);
        tick();
        mem_quiet();
        chk("f1_iack",  32'(bus_if.i_ack),   32'd1);
        chk("f1_ierr",  32'(bus_if.i_err),   32'd0);
        chk("f1_rdata", bus_if.i_rdata,      32'h0050_0093);
        chk("f1_dack",  32'(bus_if.d_ack),   32'd0);
        chk("f1_mreq",  32'(bus_if.mem_req), 32'd0);
        bus_if.i_req = 1'b0;
        tick();
        chk("f1_pulse", 32'(bus_if.i_ack),   32'd0);
        chk("f1_hold",  bus_if.i_rdata,      32'h0050_0093);

        // Tie right after reset: data first.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus_if.i_req   = 1'b1;
        bus_if.i_addr  = 32'h80;
        bus_if.d_req   = 1'b1;
        bus_if.d_we    = 1'b1;
        bus_if.d_addr  = 32'h100;
        bus_if.d_wdata = 32'hDEAD_BEEF;
        bus_if.d_be    = 4'b0011;
        tick();
        chk("t_we",    32'(bus_if.mem_we), 32'd1);
        chk("t_be",    32'(bus_if.mem_be), 32'h3);
        chk("t_addr",  bus_if.mem_addr,    32'h100);
        chk("t_wdata", bus_if.mem_wdata,   32'hDEAD_BEEF);
        mem_respond(32'd0);
        tick();
        mem_quiet();
        chk("t_dack", 32'(bus_if.d_ack), 32'd1);
        chk("t_iack", 32'(bus_if.i_ack), 32'd0);
        bus_if.d_req = 1'b0;
        tick();
        tick();
        chk("t2_addr", bus_if.mem_addr,    32'h80);
        chk("t2_we",   32'(bus_if.mem_we), 32'd0);
        chk("t2_be",   32'(bus_if.mem_be), 32'hF);
        mem_respond(32'h1111_1111);
        tick();
        mem_quiet();
        chk("t2_iack",  32'(bus_if.i_ack), 32'd1);
        chk("t2_dack",  32'(bus_if.d_ack), 32'd0);
        chk("t2_rdata", bus_if.i_rdata,    32'h1111_1111);
        bus_if.i_req = 1'b0;
        tick();

        // Sustained contention: D,I,D,I,D,I.
        exp_q = {32'd1, 32'd0, 32'd1, 32'd0, 32'd1, 32'd0};
        bus_if.i_req   = 1'b1;
        bus_if.i_addr  = 32'h80;
        bus_if.d_req   = 1'b1;
        bus_if.d_we    = 1'b1;
        bus_if.d_be    = 4'hC;
        bus_if.d_addr  = 32'h100;
        bus_if.d_wdata = 32'hCAFE_0000;
        for (int k = 0; k < 6; k++) begin
            chk("c_idle", 32'(state), 32'(ST_IDLE));
            tick();
            exp_tag = exp_q.pop_front();
            chk("c_addr", bus_if.mem_addr,    exp_tag[0] ? 32'h100 : 32'h80);
            chk("c_we",   32'(bus_if.mem_we), 32'(exp_tag[0]));
            mem_respond(32'hA0 + 32'(k));
            tick();
            mem_quiet();
            chk("c_dack",  32'(bus_if.d_ack), 32'(exp_tag[0]));
            chk("c_iack",  32'(bus_if.i_ack), 32'(!exp_tag[0]));
            chk("c_rdata", exp_tag[0] ? bus_if.d_rdata : bus_if.i_rdata, 32'hA0 + 32'(k));
            tick();
        end
        bus_if.i_req = 1'b0;
        bus_if.d_req = 1'b0;

        // Timeout on a lone data load.
        bus_if.d_req  = 1'b1;
        bus_if.d_we   = 1'b0;
        bus_if.d_be   = 4'hF;
        bus_if.d_addr = 32'h200;
        tick();
        for (int c = 1; c <= 4; c++) begin
            chk("to_req",  32'(bus_if.mem_req), 32'd1);
            chk("to_dack", 32'(bus_if.d_ack),   32'd0);
            tick();
        end
        chk("to_mreq",  32'(bus_if.mem_req), 32'd0);
        chk("to_ack",   32'(bus_if.d_ack),   32'd1);
        chk("to_err",   32'(bus_if.d_err),   32'd1);
        chk("to_rdata", bus_if.d_rdata,      32'd0);
        chk("to_iack",  32'(bus_if.i_ack),   32'd0);
        bus_if.d_req = 1'b0;
        tick();
        mem_respond(32'hFFFF_FFFF);
        tick();
        mem_quiet();
        chk("late_dack",  32'(bus_if.d_ack),   32'd0);
        chk("late_iack",  32'(bus_if.i_ack),   32'd0);
        chk("late_mreq",  32'(bus_if.mem_req), 32'd0);
        chk("late_drd",   bus_if.d_rdata,      32'd0);
        chk("late_ird",   bus_if.i_rdata,      32'hA5);
        chk("late_state", 32'(state),          32'(ST_IDLE));

        // Ack on the last BUSY cycle wins; requester drops i_req while BUSY.
        bus_if.i_req  = 1'b1;
        bus_if.i_addr = 32'h300;
        tick();
        chk("col_addr", bus_if.mem_addr, 32'h300);
        bus_if.i_req = 1'b0;
        tick();
        tick();
        tick();
        chk("col_req4", 32'(bus_if.mem_req), 32'd1);
        mem_respond(32'h1234_5678);
        tick();
        mem_quiet();
        chk("col_iack",  32'(bus_if.i_ack), 32'd1);
        chk("col_ierr",  32'(bus_if.i_err), 32'd0);
        chk("col_rdata", bus_if.i_rdata,    32'h1234_5678);
        chk("col_dack",  32'(bus_if.d_ack), 32'd0);
        tick();
        chk("col_pulse", 32'(bus_if.i_ack), 32'd0);
        chk("col_idle",  32'(state),        32'(ST_IDLE));

        // Reset in the middle of a data transaction.
        bus_if.d_req  = 1'b1;
        bus_if.d_we   = 1'b1;
        bus_if.d_addr = 32'h600;
        tick();
        chk("rb_req", 32'(bus_if.mem_req), 32'd1);
        rst = 1'b1;
        bus_if.d_req = 1'b0;
        tick();
        rst = 1'b0;
        chk("rb_mreq",  32'(bus_if.mem_req), 32'd0);
        chk("rb_state", 32'(state),          32'(ST_IDLE));
        chk("rb_dack",  32'(bus_if.d_ack),   32'd0);
        chk("rb_ird",   bus_if.i_rdata,      32'd0);
        tick();
        mem_respond(32'h5555_5555);
        tick();
        mem_quiet();
        chk("rb_late_d", 32'(bus_if.d_ack), 32'd0);
        chk("rb_late_i", 32'(bus_if.i_ack), 32'd0);
        chk("rb_drd",    bus_if.d_rdata,    32'd0);
        bus_if.i_req  = 1'b1;
        bus_if.i_addr = 32'h500;
        bus_if.d_req  = 1'b1;
        bus_if.d_we   = 1'b0;
        bus_if.d_be   = 4'b0101;
        bus_if.d_addr = 32'h400;
        tick();
        chk("rb_tie_addr", bus_if.mem_addr,    32'h400);
        chk("rb_tie_we",   32'(bus_if.mem_we), 32'd0);
        chk("rb_tie_be",   32'(bus_if.mem_be), 32'h5);
        mem_respond(32'h77);
        tick();
        mem_quiet();
        bus_if.i_req = 1'b0;
        bus_if.d_req = 1'b0;
        chk("rb_tie_dack", 32'(bus_if.d_ack), 32'd1);
        chk("rb_tie_iack", 32'(bus_if.i_ack), 32'd0);
        chk("rb_tie_rd",   bus_if.d_rdata,    32'h77);
        tick();
        tick();

        // ---------------- report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
